// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Scan controller for a multiplexed seven-segment display of WIDTH digits.
//   Each digit gets a slot of SLOT_CYCLES clocks. The first BLANK_CYCLES clocks
//   of a slot are dead time with all anodes off, which prevents ghosting. The
//   rest of the slot is PWM-dimmed by brightness against slot_cnt[3:0].
//   New values land in a pending buffer and are copied into the shadow
//   (displayed) buffer only at a frame boundary, so a frame is never torn.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   load         in   single-cycle strobe, captures value/dp into the pending buffer
//   value        in   4*WIDTH hex digits, digit i at [4i+3:4i]
//   dp           in   per-digit decimal point, active high
//   lz_blank     in   leading-zero blanking enable (level)
//   brightness   in   PWM duty, 0 = dark, 15 = 15/16
//   digit_value  out  shadow nibble of the active digit
//   digit_dp     out  shadow dp of the active digit
//   anodes       out  active-low digit enables, at most one low
//   frame_start  out  one-cycle pulse when scanning returns to digit 0
//   pending      out  high while a loaded value awaits commit
//
// Load protocol: load is a fire-and-forget strobe with no ready. It is always
// accepted. A later load before commit overwrites the buffer (last write wins).

module seven_segment_scanner #(
    parameter int WIDTH        = 3,
    parameter int SLOT_CYCLES  = 16384,
    parameter int BLANK_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [4*WIDTH-1:0]   value,
    input  logic [WIDTH-1:0]     dp,
    input  logic                 lz_blank,
    input  logic [3:0]           brightness,
    output logic [3:0]           digit_value,
    output logic                 digit_dp,
    output logic [WIDTH-1:0]     anodes,
    output logic                 frame_start,
    output logic                 pending
);

    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0]      slot_cnt_q,    slot_cnt_d;
    logic [AW-1:0]      active_q,      active_d;
    logic [4*WIDTH-1:0] shadow_val_q,  shadow_val_d;
    logic [WIDTH-1:0]   shadow_dp_q,   shadow_dp_d;
    logic [4*WIDTH-1:0] pend_val_q,    pend_val_d;
    logic [WIDTH-1:0]   pend_dp_q,     pend_dp_d;
    logic               pending_q,     pending_d;
    logic [WIDTH-1:0]   anodes_q,      anodes_d;
    logic [3:0]         digit_value_q, digit_value_d;
    logic               digit_dp_q,    digit_dp_d;
    logic               frame_start_q, frame_start_d;

    logic slot_last;
    logic act_last;
    logic frame_wrap;
    logic upper_zero;
    logic blank;
    logic lit;

    always_comb begin
        slot_last     = (slot_cnt_q == CW'(SLOT_CYCLES - 1));
        act_last      = (active_q == AW'(WIDTH - 1));
        frame_wrap    = slot_last && act_last;

        slot_cnt_d    = slot_last ? '0 : slot_cnt_q + CW'(1);
        active_d      = active_q;
        shadow_val_d  = shadow_val_q;
        shadow_dp_d   = shadow_dp_q;
        pend_val_d    = pend_val_q;
        pend_dp_d     = pend_dp_q;
        pending_d     = pending_q;
        frame_start_d = frame_wrap;
        digit_value_d = '0;
        digit_dp_d    = 1'b0;
        upper_zero    = 1'b1;

        if (slot_last) begin
            active_d = act_last ? '0 : active_q + AW'(1);
        end

        // Commit happens before the load capture so that a load on the
        // boundary cycle refills the buffer and leaves pending set.
        if (frame_wrap && pending_q) begin
            shadow_val_d = pend_val_q;
            shadow_dp_d  = pend_dp_q;
            pending_d    = 1'b0;
        end
        if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp;
            pending_d  = 1'b1;
        end

        // Select the active digit from the shadow buffer. Also check whether
        // this digit and every more-significant digit are zero.
        for (int i = 0; i < WIDTH; i++) begin
            if (active_q == AW'(i)) begin
                digit_value_d = shadow_val_q[4*i +: 4];
                digit_dp_d    = shadow_dp_q[i];
            end
            if ((AW'(i) >= active_q) && (shadow_val_q[4*i +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end

        blank    = lz_blank && (active_q != '0) && upper_zero;
        lit      = (slot_cnt_q >= CW'(BLANK_CYCLES)) &&
                   (slot_cnt_q[3:0] < brightness) && !blank;
        anodes_d = lit ? ~(WIDTH'(1) << active_q) : '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q    <= '0;
            active_q      <= '0;
            shadow_val_q  <= '0;
            shadow_dp_q   <= '0;
            pend_val_q    <= '0;
            pend_dp_q     <= '0;
            pending_q     <= 1'b0;
            anodes_q      <= '1;
            digit_value_q <= '0;
            digit_dp_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            active_q      <= active_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            pend_val_q    <= pend_val_d;
            pend_dp_q     <= pend_dp_d;
            pending_q     <= pending_d;
            anodes_q      <= anodes_d;
            digit_value_q <= digit_value_d;
            digit_dp_q    <= digit_dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign digit_value = digit_value_q;
    assign digit_dp    = digit_dp_q;
    assign anodes      = anodes_q;
    assign frame_start = frame_start_q;
    assign pending     = pending_q;

endmodule
